kamus_div_ctrl: RTL and testbench

Iterative radix-2 divide sequencer for the EX stage. It implements the RV32M DIV, DIVU, REM and REMU operations, which the single-cycle execute datapath cannot cover. The EX/issue logic hands it operands through a start/ready handshake and holds the pipeline while busy_o is high. The block owns the operand latches, the iteration counter, sign fix-up and the RISC-V special-case results.

---
 rtl/kamus_div_ctrl.sv | 152 +++++++++++++++
 tb/tb_kamus_div_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/kamus_div_ctrl.sv
// Radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Define KAMUS_DIV_FLUSH_EN to add the flush_i pipeline-kill input.
//
// state | meaning
// IDLE  | waiting for start_i, ready_o high
// CALC  | one restoring step per cycle, WIDTH steps
// DONE  | result_o valid, done_o pulse for one cycle
module kamus_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef KAMUS_DIV_FLUSH_EN
    input  logic             flush_i,
`endif
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic             r_is_rem;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_result;

    logic             w_flush;
    logic             w_accept;
    logic             w_signed;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_res;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_calc_res;

`ifdef KAMUS_DIV_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // op_i[0]=0 selects the signed variants, op_i[1]=1 selects remainder
    assign w_signed   = ~op_i[0];
    assign w_div_zero = (divisor_i == '0);
    assign w_ovf      = w_signed && (dividend_i == INT_MIN) && (divisor_i == '1);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = op_i[1] ? dividend_i : '1;
        else
            w_special_res = op_i[1] ? '0 : INT_MIN;
    end

    assign w_a_abs = (w_signed && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign w_b_abs = (w_signed && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    // Shifted remainder keeps its carry bit so divisors with the MSB set compare correctly
    assign w_rem_sh   = {r_rem, r_q[WIDTH-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_nxt  = w_ge ? (w_rem_sh[WIDTH-1:0] - r_div) : w_rem_sh[WIDTH-1:0];
    assign w_q_nxt    = {r_q[WIDTH-2:0], w_ge};
    assign w_calc_res = r_is_rem ? (r_r_neg ? -w_rem_nxt : w_rem_nxt)
                                 : (r_q_neg ? -w_q_nxt   : w_q_nxt);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC:  if (r_cnt == LAST_STEP) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_flush && (r_state != S_IDLE))
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_is_rem <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_cnt    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_is_rem <= op_i[1];
            r_q_neg  <= w_signed && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            r_r_neg  <= w_signed && dividend_i[WIDTH-1];
            r_cnt    <= '0;
            r_q      <= w_a_abs;
            r_rem    <= '0;
            r_div    <= w_b_abs;
            if (w_special)
                r_result <= w_special_res;
        end else if ((r_state == S_CALC) && !w_flush) begin
            r_q   <= w_q_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_STEP)
                r_result <= w_calc_res;
        end
    end

    assign busy_o   = (r_state != S_IDLE);
    assign ready_o  = ~busy_o;
    assign done_o   = (r_state == S_DONE) && !w_flush;
    assign result_o = r_result;

endmodule

// File: tb/tb_kamus_div_ctrl.sv
// Self-checking bench for kamus_div_ctrl: directed literal cases plus randomized traffic
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_kamus_div_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ready_o;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  result_o;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    kamus_div_ctrl #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
`ifdef KAMUS_DIV_FLUSH_EN
        .flush_i    (flush),
`endif
        .start_i    (start),
        .op_i       (op),
        .dividend_i (a),
        .divisor_i  (b),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension semantics straight from the ISA rules
    function automatic logic [W-1:0] ref_div(input logic [1:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        int sx, sy;
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                return o[1] ? 32'h0 : 32'h8000_0000;
            sx = signed'(x);
            sy = signed'(y);
            return o[1] ? 32'(sx % sy) : 32'(sx / sy);
        end
        return o[1] ? (x % y) : (x / y);
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [W-1:0] x,
                                      input logic [W-1:0] y);
        return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // Reference model: m_left counts cycles until the done cycle (1 = done this cycle)
    bit           m_busy = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy   = 1'b0;
            m_left   = 0;
            m_result = '0;
        end else if (m_busy && flush) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_pend = ref_div(op, a, b);
                m_busy = 1'b1;
                if (is_special(op, a, b)) begin
                    m_left   = 1;
                    m_result = m_pend;
                end else begin
                    m_left = W + 1;
                end
            end
        end else if (m_left == 1) begin
            m_busy = 1'b0;
        end else begin
            m_left--;
            if (m_left == 1) m_result = m_pend;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("ready_o", {31'b0, ready_o}, {31'b0, !m_busy});
            chk("busy_o", {31'b0, busy_o}, {31'b0, m_busy});
            chk("done_o", {31'b0, done_o}, {31'b0, m_busy && (m_left == 1) && !flush});
            chk("result_o", result_o, m_result);
        end
    end

    // kind: 0 none, 1 ignored start 50/5, 2 reset, 3 flush; applied during cycle poke_at
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int poke_at, input int kind,
                         output int lat, output logic [W-1:0] res, output bit seen);
        int k;
        seen = 1'b0;
        lat  = -1;
        res  = '0;
        @(negedge clk);
        k = 0;
        while (!ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!ready_o) chk("ready_wait", {31'b0, ready_o}, 32'd1);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 45; c++) begin
            start = 1'b0; rst = 1'b0; flush = 1'b0;
            if (c == poke_at) begin
                case (kind)
                    1: begin start = 1'b1; op = 2'd1; a = 32'd50; b = 32'd5; end
                    2: rst = 1'b1;
                    3: flush = 1'b1;
                    default: ;
                endcase
            end
            #1;
            if (done_o) begin
                seen = 1'b1;
                lat  = c;
                res  = result_o;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0; rst = 1'b0; flush = 1'b0;
    endtask

    logic [1:0]   d_op  [10] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0, 2'd2, 2'd1};
    logic [W-1:0] d_a   [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                                 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] d_b   [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    logic [W-1:0] d_exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                                 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0, 32'd1};
    int           d_lat [10] = '{33, 33, 33, 33, 33, 1, 1, 1, 1, 33};

    initial begin
        int           lat;
        logic [W-1:0] res;
        bit           seen;
        int           sel;

        rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        rst = 1'b0;

        chk("model_divu", ref_div(2'd1, 32'd100, 32'd7), 32'd14);
        chk("model_div_neg", ref_div(2'd0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model_rem_ovf", ref_div(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

        for (int i = 0; i < 10; i++) begin
            do_op(d_op[i], d_a[i], d_b[i], 0, 0, lat, res, seen);
            chk($sformatf("dir%0d_done", i), {31'b0, seen}, 32'd1);
            chk($sformatf("dir%0d_lat", i), lat, d_lat[i]);
            chk($sformatf("dir%0d_res", i), res, d_exp[i]);
        end

        do_op(2'd1, 32'd100, 32'd7, 10, 1, lat, res, seen);
        chk("ignored_start_lat", lat, 33);
        chk("ignored_start_res", res, 32'd14);

`ifdef KAMUS_DIV_FLUSH_EN
        do_op(2'd1, 32'd100, 32'd7, 15, 3, lat, res, seen);
        chk("flush_no_done", {31'b0, seen}, 32'd0);
        chk("flush_result_kept", result_o, 32'd14);
        chk("flush_ready", {31'b0, ready_o}, 32'd1);
        do_op(2'd3, 32'd100, 32'd7, 0, 0, lat, res, seen);
        chk("after_flush_res", res, 32'd2);
        chk("after_flush_lat", lat, 33);
`endif

        do_op(2'd1, 32'd100, 32'd7, 20, 2, lat, res, seen);
        chk("reset_no_done", {31'b0, seen}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_ready", {31'b0, ready_o}, 32'd1);

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            sel   = $urandom_range(0, 7);
            case (sel)
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: begin a = $urandom; b = {1'b1, 31'($urandom)}; end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            rst = ($urandom_range(0, 299) == 0);
`ifdef KAMUS_DIV_FLUSH_EN
            flush = ($urandom_range(0, 39) == 0);
`endif
        end
        @(negedge clk);
        start = 1'b0; rst = 1'b0; flush = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
